change_capture: RTL and testbench

Downstream trace stage that watches a registered 16-bit signal, such as the output of a flop stage, and records every value change as a (timestamp, value) entry. Entries go into a small FIFO and are drained through a valid/ready port by the debug/trace sink. The block lets the debugger reconstruct a signal's history without dumping every cycle. A free-running cycle counter provides the timestamps, and a sticky flag reports entries lost to back-pressure.

---
 rtl/change_capture_pkg.sv | 13 +
 rtl/sync_fifo.sv | 52 +++++
 rtl/change_capture.sv | 72 +++++++
 tb/tb_change_capture.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/change_capture_pkg.sv
// Shared defaults and sizing helpers for the change_capture trace stage.
package change_capture_pkg;

    localparam int WIDTH_DEF    = 16;
    localparam int TS_WIDTH_DEF = 16;
    localparam int DEPTH_DEF    = 8;

    // Pointers carry one extra wrap bit so full and empty can be told apart.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock in-order FIFO with wrap-bit pointers and a registered storage array.
module sync_fifo
    import change_capture_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = DEPTH_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [DATA_WIDTH-1:0]        push_data,
    input  logic                         pop,
    output logic [DATA_WIDTH-1:0]        pop_data,
    output logic                         full,
    output logic                         empty,
    output logic [ptr_width(DEPTH)-1:0]  count
);

    localparam int PW = ptr_width(DEPTH);
    localparam int AW = PW - 1;

    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  do_push;
    logic                  do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A full FIFO still takes a push when the head leaves on the same edge.
    assign do_push = push && (!full || do_pop);
    assign count   = wr_ptr - rd_ptr;
    assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: storage is not reset; the pointers alone define which slots hold valid data.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/change_capture.sv
// Records every change of an observed signal as a (timestamp, value) entry in a drainable FIFO.
module change_capture
    import change_capture_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEF,
    parameter int TS_WIDTH = TS_WIDTH_DEF,
    parameter int DEPTH    = DEPTH_DEF
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en,
    input  logic [WIDTH-1:0]            sample,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WIDTH-1:0]            out_value,
    output logic [TS_WIDTH-1:0]         out_ts,
    output logic [ptr_width(DEPTH)-1:0] count,
    output logic                        overflow,
    input  logic                        clear_overflow
);

    logic [TS_WIDTH-1:0]       ts;
    logic [WIDTH-1:0]          last;
    logic                      primed;
    logic                      capture;
    logic                      pop;
    logic                      full;
    logic                      empty;
    logic                      drop;
    logic [TS_WIDTH+WIDTH-1:0] head;

    // An unprimed capture fires regardless of value so the sink always sees a starting point.
    assign capture   = en && (!primed || (sample != last));
    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;
    assign drop      = capture && full && !pop;
    assign {out_ts, out_value} = head;

    sync_fifo #(
        .DATA_WIDTH (TS_WIDTH + WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (capture),
        .push_data ({ts, sample}),
        .pop       (pop),
        .pop_data  (head),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ts       <= '0;
            last     <= '0;
            primed   <= 1'b0;
            overflow <= 1'b0;
        end else begin
            ts <= ts + 1'b1;
            // last follows even dropped captures so the next compare is against the true value.
            if (capture) last <= sample;
            primed <= en ? (primed || capture) : 1'b0;
            if (drop)
                overflow <= 1'b1;
            else if (clear_overflow)
                overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_change_capture.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based model.
module tb_change_capture;

    localparam int D = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        out_ready = 1'b0;
    logic        clear_overflow = 1'b0;
    logic [15:0] sample = '0;

    logic        out_valid, out_valid2;
    logic [15:0] out_value, out_value2;
    logic [15:0] out_ts;
    logic [3:0]  out_ts2;
    logic [3:0]  count, count2;
    logic        overflow, overflow2;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int          ts;
        logic [15:0] val;
    } entry_t;

    entry_t      q[$];
    entry_t      popped[$];
    int          m_ts = 0;
    logic [15:0] m_last = '0;
    bit          m_primed = 1'b0;
    bit          m_ovf = 1'b0;

    always #5 clk = ~clk;

    change_capture dut (
        .clk(clk), .rst_n(rst_n), .en(en), .sample(sample),
        .out_valid(out_valid), .out_ready(out_ready), .out_value(out_value),
        .out_ts(out_ts), .count(count), .overflow(overflow),
        .clear_overflow(clear_overflow)
    );

    change_capture #(.TS_WIDTH(4)) dut_short (
        .clk(clk), .rst_n(rst_n), .en(en), .sample(sample),
        .out_valid(out_valid2), .out_ready(out_ready), .out_value(out_value2),
        .out_ts(out_ts2), .count(count2), .overflow(overflow2),
        .clear_overflow(clear_overflow)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model advances on each edge from the spec rules, then both DUTs are compared 1 time unit later.
    always @(posedge clk) begin : model_p
        bit     do_pop;
        bit     cap;
        bit     acc;
        entry_t e;
        int     exp_ts;
        int     exp_val;
        if (!rst_n) begin
            q.delete();
            m_ts     = 0;
            m_last   = '0;
            m_primed = 1'b0;
            m_ovf    = 1'b0;
        end else begin
            do_pop = (q.size() > 0) && out_ready;
            cap    = en && (!m_primed || sample != m_last);
            acc    = (q.size() < D) || do_pop;
            if (do_pop) popped.push_back(q.pop_front());
            if (cap && acc) begin
                e.ts  = m_ts;
                e.val = sample;
                q.push_back(e);
            end
            if (cap && !acc) m_ovf = 1'b1;
            else if (clear_overflow) m_ovf = 1'b0;
            if (cap) m_last = sample;
            if (!en) m_primed = 1'b0;
            else if (cap) m_primed = 1'b1;
            m_ts = (m_ts + 1) % 65536;
        end
        #1;
        exp_ts  = (q.size() > 0) ? q[0].ts : 0;
        exp_val = (q.size() > 0) ? int'(q[0].val) : 0;
        check("out_valid", out_valid, q.size() != 0);
        check("count", count, q.size());
        check("overflow", overflow, m_ovf);
        check("out_value", out_value, exp_val);
        check("out_ts", out_ts, exp_ts);
        check("short_out_valid", out_valid2, q.size() != 0);
        check("short_count", count2, q.size());
        check("short_overflow", overflow2, m_ovf);
        check("short_out_value", out_value2, exp_val);
        check("short_out_ts", out_ts2, exp_ts % 16);
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; en = 1'b0; out_ready = 1'b0; clear_overflow = 1'b0; sample = '0;
        tick(2);
        rst_n = 1'b1;
        popped.delete();
    endtask

    initial begin
        // Basic capture: one prime entry, one change entry.
        tick(1);
        do_reset();
        check("reset_valid", out_valid, 0);
        check("reset_count", count, 0);
        en = 1'b1; sample = 16'h0000;
        tick(3);
        sample = 16'h0005;
        tick(1);
        check("basic_count", count, 2);
        out_ready = 1'b1;
        tick(3);
        check("basic_n", popped.size(), 2);
        if (popped.size() == 2) begin
            check("basic_e0", {popped[0].ts[15:0], popped[0].val}, {16'd0, 16'h0000});
            check("basic_e1", {popped[1].ts[15:0], popped[1].val}, {16'd3, 16'h0005});
        end

        // Incrementing stream every 10 cycles.
        do_reset();
        en = 1'b1; out_ready = 1'b1;
        for (int v = 0; v < 10; v++) begin
            sample = 16'(v);
            tick(10);
        end
        tick(2);
        check("stream_n", popped.size(), 10);
        for (int i = 0; i < 10 && i < popped.size(); i++)
            check("stream_e", {popped[i].ts[15:0], popped[i].val}, {16'(i * 10), 16'(i)});

        // Overflow with the sink stalled.
        do_reset();
        en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            sample = 16'(i + 1);
            tick(1);
        end
        check("ovf_count", count, 8);
        check("ovf_flag", overflow, 1);
        out_ready = 1'b1;
        tick(10);
        check("ovf_drain_n", popped.size(), 8);
        for (int i = 0; i < 8 && i < popped.size(); i++)
            check("ovf_drain_e", {popped[i].ts[15:0], popped[i].val}, {16'(i), 16'(i + 1)});
        check("ovf_sticky", overflow, 1);
        clear_overflow = 1'b1;
        tick(1);
        clear_overflow = 1'b0;
        check("ovf_cleared", overflow, 0);

        // Full FIFO with push and pop on the same edge, then re-enable.
        do_reset();
        en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            sample = 16'h0100 + 16'(i);
            tick(1);
        end
        check("full_count", count, 8);
        sample = 16'h0200; out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
        check("full_pp_count", count, 8);
        check("full_pp_ovf", overflow, 0);
        out_ready = 1'b1;
        tick(10);
        out_ready = 1'b0;
        en = 1'b0;
        tick(1);
        en = 1'b1;
        tick(3);
        check("reprime_count", count, 1);

        // Timestamp wrap on the 4-bit instance: changes at cycles 14 and 17.
        do_reset();
        en = 1'b1; out_ready = 1'b1; sample = 16'h0000;
        tick(14);
        sample = 16'h0001;
        tick(3);
        sample = 16'h0002;
        tick(3);
        check("wrap_n", popped.size(), 3);
        if (popped.size() == 3) begin
            check("wrap_ts1", popped[1].ts % 16, 14);
            check("wrap_ts2", popped[2].ts % 16, 1);
        end

        // Reset mid-drain with overflow set and 5 entries queued.
        do_reset();
        en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            sample = 16'h0040 + 16'(i);
            tick(1);
        end
        out_ready = 1'b1;
        tick(3);
        out_ready = 1'b0;
        check("pre_rst_count", count, 5);
        check("pre_rst_ovf", overflow, 1);
        rst_n = 1'b0;
        tick(1);
        check("rst_valid", out_valid, 0);
        check("rst_count", count, 0);
        check("rst_ovf", overflow, 0);
        rst_n = 1'b1; sample = 16'h0077;
        tick(1);
        check("rst_restart_valid", out_valid, 1);
        check("rst_restart_ts", out_ts, 0);

        // Random traffic; the compare process checks every cycle.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            en             = ($urandom_range(0, 7) != 0);
            sample         = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 3));
            out_ready      = (n % 400 < 200) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            clear_overflow = ($urandom_range(0, 15) == 0);
            rst_n          = ($urandom_range(0, 299) != 0);
            tick(1);
        end
        rst_n = 1'b1;
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
